// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 800x600@60 raster constants and decode helpers
package vga_pkg;

  localparam int CNT_W   = 12;
  localparam int CNT_MAX = 1 << CNT_W;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 40;
  localparam int H_SYNC_DEF   = 128;
  localparam int H_BP_DEF     = 88;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BP_DEF     = 23;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam logic SYNC_POL_DEF = 1'b1;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic logic in_window(input logic [CNT_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_axis_timing.sv
// rtl/vga_axis_timing.sv - one raster axis: position counter with blank/sync decode
module vga_axis_timing
  import vga_pkg::*;
#(
  parameter int   ACTIVE   = H_ACTIVE_DEF,
  parameter int   FP       = H_FP_DEF,
  parameter int   SYNC     = H_SYNC_DEF,
  parameter int   BP       = H_BP_DEF,
  parameter logic SYNC_POL = SYNC_POL_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             blnk,
  output logic             sync,
  output logic             wrap
);

  localparam int               TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int               SYNC_START = ACTIVE + FP;
  localparam int               SYNC_END   = ACTIVE + FP + SYNC;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_nxt;

  assign wrap = step && (count == LAST);

  always_comb begin
    count_nxt = count;
    if (step) begin
      count_nxt = (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  // Decode from the next count so blank/sync land in the same register stage as the count.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count <= '0;
      blnk  <= 1'b0;
      sync  <= ~SYNC_POL;
    end else begin
      count <= count_nxt;
      blnk  <= (int'(count_nxt) >= ACTIVE);
      sync  <= in_window(count_nxt, SYNC_START, SYNC_END) ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing source: hcount/vcount with sync, blank and frame_start
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = SYNC_POL_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic             frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  generate
    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_param_err
      $error("vga_timing_gen: raster %0dx%0d does not fit %0d-bit counters", H_TOTAL, V_TOTAL, CNT_W);
    end
  endgenerate

  logic h_wrap;
  logic v_wrap;
  logic v_step;

  assign v_step = en && h_wrap;

  vga_axis_timing #(
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SYNC_POL (SYNC_POL)
  ) u_h_axis (
    .clk_in (clk_in),
    .rst    (rst),
    .step   (en),
    .count  (hcount_out),
    .blnk   (hblnk_out),
    .sync   (hsync_out),
    .wrap   (h_wrap)
  );

  vga_axis_timing #(
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_v_axis (
    .clk_in (clk_in),
    .rst    (rst),
    .step   (v_step),
    .count  (vcount_out),
    .blnk   (vblnk_out),
    .sync   (vsync_out),
    .wrap   (v_wrap)
  );

  // v_wrap means both counters roll over on this edge, so the next position shown is (0,0).
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen at default and 8x8 raster sizes
module tb_vga_timing_gen;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst, en, rst_s, en_s;
  logic [11:0] hcount, vcount, hcount_s, vcount_s;
  logic        hsync, hblnk, vsync, vblnk, fs;
  logic        hsync_s, hblnk_s, vsync_s, vblnk_s, fs_s;

  int n_cmp = 0;
  int n_bad = 0;

  vga_timing_gen dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .hcount_out  (hcount),
    .hsync_out   (hsync),
    .hblnk_out   (hblnk),
    .vcount_out  (vcount),
    .vsync_out   (vsync),
    .vblnk_out   (vblnk),
    .frame_start (fs)
  );

  vga_timing_gen #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1)
  ) dut_s (
    .clk_in      (clk_in),
    .rst         (rst_s),
    .en          (en_s),
    .hcount_out  (hcount_s),
    .hsync_out   (hsync_s),
    .hblnk_out   (hblnk_s),
    .vcount_out  (vcount_s),
    .vsync_out   (vsync_s),
    .vblnk_out   (vblnk_s),
    .frame_start (fs_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hcount"}, hcount, 0);
    check({tag, "_vcount"}, vcount, 0);
    check({tag, "_hblnk"},  hblnk,  0);
    check({tag, "_vblnk"},  vblnk,  0);
    check({tag, "_hsync"},  hsync,  0);
    check({tag, "_vsync"},  vsync,  0);
    check({tag, "_fs"},     fs,     0);
  endtask

  initial begin
    int e, h, v, target, iter;
    int hs_cnt, hs_first, hs_last;
    int fs_cnt, fs_first;
    logic fs_exp;

    rst = 1'b1; en = 1'b0; rst_s = 1'b1; en_s = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");

    // release with en=1, away from the clock edge
    en = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("release_hcount", hcount, 0);
    check("release_fs", fs, 0);
    tick();
    check("edge1_hcount", hcount, 1);
    check("edge1_vcount", vcount, 0);

    // free-run through line 0 and into line 1 up to hcount 799
    e = 1; hs_cnt = 0; hs_first = -1; hs_last = -1;
    while (e < 1056 + 799) begin
      tick();
      e++;
      h = e % 1056;
      v = e / 1056;
      check("line_hcount", hcount, h);
      check("line_vcount", vcount, v);
      check("line_hblnk", hblnk, (h >= 800));
      check("line_hsync", hsync, (h >= 840 && h <= 967));
      check("line_vblnk", vblnk, 0);
      check("line_vsync", vsync, 0);
      check("line_fs", fs, 0);
      if (v == 0 && hsync === 1'b1) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(hcount);
        hs_last = int'(hcount);
      end
    end
    check("hsync_width", hs_cnt, 128);
    check("hsync_first", hs_first, 840);
    check("hsync_last", hs_last, 967);

    // hold at hcount 799 for 5 cycles
    en = 1'b0;
    repeat (5) begin
      tick();
      check("hold_hcount", hcount, 799);
      check("hold_vcount", vcount, 1);
      check("hold_hblnk", hblnk, 0);
      check("hold_hsync", hsync, 0);
      check("hold_fs", fs, 0);
    end
    en = 1'b1;
    tick();
    e++;
    check("resume_hcount", hcount, 800);
    check("resume_hblnk", hblnk, 1);
    check("resume_vcount", vcount, 1);

    // asynchronous reset mid-line at (500,2)
    target = 2 * 1056 + 500;
    while (e < target) begin
      tick();
      e++;
    end
    check("pre_rst_hcount", hcount, 500);
    check("pre_rst_vcount", vcount, 2);
    #3 rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    tick();
    #2 rst = 1'b0;
    #1;
    check("rst_rel_hcount", hcount, 0);
    tick();
    check("restart_hcount", hcount, 1);
    check("restart_vcount", vcount, 0);

    // 8x8 raster, 3 frames, en dropped every fifth cycle
    #1 rst_s = 1'b0;
    en_s = 1'b1;
    #1;
    check("small_rel_hcount", hcount_s, 0);
    check("small_rel_vsync", vsync_s, 0);
    check("small_rel_fs", fs_s, 0);
    e = 0; iter = 0; fs_cnt = 0; fs_first = -1;
    while (e < 192 && iter < 400) begin
      en_s = (iter % 5 != 3);
      tick();
      iter++;
      if (en_s) e++;
      h = e % 8;
      v = (e / 8) % 8;
      fs_exp = en_s && h == 0 && v == 0;
      check("small_hcount", hcount_s, h);
      check("small_vcount", vcount_s, v);
      check("small_hblnk", hblnk_s, (h >= 4));
      check("small_hsync", hsync_s, (h >= 5 && h <= 6));
      check("small_vblnk", vblnk_s, (v >= 4));
      check("small_vsync", vsync_s, (v >= 5 && v <= 6));
      check("small_fs", fs_s, fs_exp);
      if (fs_s === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = e;
      end
    end
    check("small_budget", e, 192);
    check("small_fs_count", fs_cnt, 3);
    check("small_fs_first_edge", fs_first, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing source for the VGA pixel pipeline. It produces the hcount/vcount/sync/blank stream that every draw stage consumes and re-registers. It sits at the head of the chain, ahead of the background and object-drawing stages. It generates the timing only and carries no RGB.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1, asserted level of hsync/vsync (1 = positive)

Ports:
- clk_in  input  1  pixel clock
- rst  input  1  reset, asynchronous, active-high
- en  input  1  pixel advance enable; all state holds while low
- hcount_out  output  12  current pixel column, 0..H_TOTAL-1
- hsync_out  output  1  horizontal sync at level SYNC_POL
- hblnk_out  output  1  horizontal blank, active-high
- vcount_out  output  12  current line, 0..V_TOTAL-1
- vsync_out  output  1  vertical sync at level SYNC_POL
- vblnk_out  output  1  vertical blank, active-high
- frame_start  output  1  one-cycle pulse while the outputs show (0,0)

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1056; V_TOTAL = 628. Both must be ≤ 4096. Parameters are checked at elaboration.
- Counters:
  - On each clk_in edge with en=1, hcount increments.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - vcount wraps to 0 when hcount wraps at vcount = V_TOTAL-1.
- Decode (all outputs registered, mutually consistent with the hcount/vcount on the same cycle):
  - hblnk = hcount ≥ H_ACTIVE
  - hsync = SYNC_POL when H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL
  - vblnk = vcount ≥ V_ACTIVE
  - vsync asserted when V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC
  - frame_start = (hcount==0 && vcount==0) && en
- Decode is computed from the next-state counter values, so no output lags the counters.
- en=0: counters and every output except frame_start hold their value; frame_start drops to 0. When en returns to 1, counting resumes from the held position with no skipped or repeated pixel.
- Reset values: hcount_out=0, vcount_out=0, hblnk_out=0, vblnk_out=0, hsync_out=~SYNC_POL, vsync_out=~SYNC_POL, frame_start=0.
- Reset mid-frame returns immediately to (0,0) with the reset values above. The first frame_start occurs at the first wrap to (0,0) after reset release, not at release.

## Timing
- Latency 0 between counter and decoded outputs (same register stage).
- Position advances exactly one pixel per enabled edge.
- The first enabled edge after reset release shows (1,0).
- Line period is H_TOTAL enabled cycles; frame period is H_TOTAL×V_TOTAL = 663168 enabled cycles.
- hsync with default parameters: asserted at hcount 840..967 inclusive.
- vsync with default parameters: asserted for the whole of lines 601..604.
- vblnk and vsync change on the same cycle as the hcount wrap to 0.
- Outputs are glitch-free (flop-driven). Downstream stages add one cycle each.

## Structure
- Shared package vga_pkg holds:
  - 800×600@60 timing constants (H_/V_ active, FP, SYNC, BP, TOTAL)
  - counter width constant (12)
  - the SYNC_POL default
- One sub-module, vga_axis_timing, is natural. It contains one counter plus its blank/sync decode with parameters ACTIVE, FP, SYNC, BP. It has a step input and a wrap output.
  - Instantiated twice: horizontal with step=en, and vertical with step=en && h_wrap.
  - The top adds frame_start and the reset values.

## Test plan
- Reset held, then released with en=1 -> outputs (0,0), syncs low, blanks low; after 1 edge hcount=1; frame_start first high after exactly 663168 edges.
- Free-run one line -> hblnk rises at hcount 800; hsync high for 128 cycles from 840 to 967; wrap 1055->0 increments vcount.
- Free-run a full frame -> vblnk high for lines 600..627; vsync high for lines 601..604 (4×1056 cycles); frame_start high once per frame.
- Toggle en low for 5 cycles at hcount=799 -> all outputs hold; on resume the next value is 800, with hblnk rising on that cycle.
- Assert rst at hcount 500, vcount 300 -> outputs go to reset values asynchronously, before the next clock edge; after release, counting restarts at (0,0).
- Override parameters to a small raster (ACTIVE 4, FP 1, SYNC 2, BP 1; both axes) -> total 8×8; check every decoded output against a reference model for 3 frames.
